dmem_pipelined: RTL and testbench

- Parametrised successor to the CPU data-memory wrapper.
- Single-port word memory with a configurable fixed access latency, byte-lane write enables and a valid/ready request handshake, so the MEM stage can stall on memory.
- Sits between the CPU MEM stage and the storage array.
- Accepts at most one request every LAT cycles and returns a response (read data or write ack) exactly LAT cycles after acceptance.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_pipelined.sv | 107 ++++++++++
 tb/tb_dmem_pipelined.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the pipelined data-memory wrapper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the CPU MEM stage (master) and dmem_pipelined (slave).
interface dmem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word storage with byte-lane writes; the read word is captured on the access edge.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic                          re,
  input  logic [lane_count(DATA_W)-1:0] be,
  input  logic [DEPTH_LOG2-1:0]         idx,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata
);
  localparam int NB = lane_count(DATA_W);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem_q[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_pipelined.sv
// Fixed-latency data memory with valid/ready requests and one response per request.
// Optional misalignment detection when DMEM_ALIGN_CHECK_EN is defined.
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 14,
  parameter int LAT        = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
  localparam int               NB     = lane_count(DATA_W);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic                  accept;
  logic                  mis;
  logic                  arr_we;
  logic                  arr_re;
  logic [DATA_W-1:0]     arr_rdata;
  logic [DEPTH_LOG2-1:0] widx;
  logic                  unused_addr;

  assign widx = bus.req_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis         = |bus.req_addr[1:0];
  assign unused_addr = ^bus.req_addr[ADDR_W-1:DEPTH_LOG2+2];
`else
  assign mis         = 1'b0;
  assign unused_addr = ^{bus.req_addr[ADDR_W-1:DEPTH_LOG2+2], bus.req_addr[1:0]};
`endif

  assign bus.req_ready = (state_q != WAIT);
  assign accept        = bus.req_valid && bus.req_ready && !rst;
  // Misaligned accesses are timed normally but never touch the array.
  assign arr_we        = accept &&  bus.req_wr && !mis;
  assign arr_re        = accept && !bus.req_wr && !mis;

  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .be    (bus.req_be[NB-1:0]),
    .idx   (widx),
    .wdata (bus.req_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_pend_d = rd_pend_q;
    err_d     = err_q;
    // The held read word switches to the array output only during a read's RESP cycle.
    rdata_d   = (state_q == RESP && rd_pend_q) ? arr_rdata : rdata_q;

    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d   = (LAT > 1) ? WAIT : RESP;
          cnt_d     = LAT_M1;
          rd_pend_d = !bus.req_wr && !mis;
          err_d     = mis;
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_d;
  assign bus.rsp_err   = (state_q == RESP) && err_q;
endmodule

// File: tb/tb_dmem_pipelined.sv
// Bench for dmem_pipelined: three instances (LAT 2, 1, 4) against an array-based reference model.
module tb_dmem_pipelined;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int DL2  = 8;
  localparam int NDUT = 3;
  localparam int LATS [NDUT] = '{2, 1, 4};

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        vld [NDUT];
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rdy [NDUT];
  logic        rv  [NDUT];
  logic        er  [NDUT];
  logic [31:0] rd  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    assign bus.req_valid = vld[g];
    assign bus.req_wr    = req_wr;
    assign bus.req_addr  = req_addr;
    assign bus.req_wdata = req_wdata;
    assign bus.req_be    = req_be;
    assign rdy[g] = bus.req_ready;
    assign rv[g]  = bus.rsp_valid;
    assign rd[g]  = bus.rsp_rdata;
    assign er[g]  = bus.rsp_err;

    dmem_pipelined #(
      .DATA_W     (DW),
      .ADDR_W     (AW),
      .DEPTH_LOG2 (DL2),
      .LAT        (LATS[g])
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Reference: per-instance word array and last delivered read word.
  logic [31:0] mem_m   [NDUT][256];
  logic [31:0] last_rd [NDUT];
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int k, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be);
    int n;
    int w;
    bit mis;
    n = 0;
    while (rdy[k] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("ready_timeout", {31'b0, rdy[k]}, 32'd1);
    req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    vld[k] = 1'b1;
    step();
    vld[k] = 1'b0;
    w   = int'(addr[9:2]);
    mis = ALIGN_EN && (addr[1:0] != 2'b00);
    if (!mis) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mem_m[k][w][i*8 +: 8] = wdata[i*8 +: 8];
      end else begin
        last_rd[k] = mem_m[k][w];
      end
    end
    for (int i = 1; i <= LATS[k]; i++) begin
      if (i > 1) step();
      if (i < LATS[k]) begin
        chk("wait_valid", {31'b0, rv[k]},  32'd0);
        chk("wait_ready", {31'b0, rdy[k]}, 32'd0);
      end else begin
        chk("rsp_valid", {31'b0, rv[k]}, 32'd1);
        chk("rsp_rdata", rd[k], last_rd[k]);
        chk("rsp_err",   {31'b0, er[k]}, {31'b0, mis});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      vld[k] = 1'b0;
      last_rd[k] = '0;
    end
    req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;

    // Reset and idle
    rst = 1'b1;
    step();
    step();
    for (int k = 0; k < NDUT; k++) begin
      chk("reset_ready", {31'b0, rdy[k]}, 32'd1);
      chk("reset_valid", {31'b0, rv[k]},  32'd0);
      chk("reset_rdata", rd[k],           32'd0);
      chk("reset_err",   {31'b0, er[k]},  32'd0);
    end
    rst = 1'b0;
    step();

    // LAT=2 write then back-to-back read
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("raw_literal", rd[0], 32'hDEADBEEF);

    // Byte lanes
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0);
    chk("lane_literal", rd[0], 32'h11BB33DD);

    // be=0 write is a no-op but still acked
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0);

    // Fill every word of every instance so later reads are defined
    for (int k = 0; k < NDUT; k++)
      for (int w = 0; w < 256; w++)
        txn(k, 1'b1, 32'(w * 4), $urandom, 4'hF);

    // LAT=1 streaming: eight reads with req_valid held high
    req_wr = 1'b0; req_be = 4'h0;
    vld[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 32'(i * 4);
      step();
      last_rd[1] = mem_m[1][i];
      chk("stream_valid", {31'b0, rv[1]}, 32'd1);
      chk("stream_rdata", rd[1], mem_m[1][i]);
    end
    vld[1] = 1'b0;
    step();
    chk("stream_idle", {31'b0, rv[1]}, 32'd0);

    // Reset mid-operation on LAT=4; the earlier write must survive
    txn(2, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    req_wr = 1'b0; req_addr = 32'h40;
    vld[2] = 1'b1;
    step();
    vld[2] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) last_rd[k] = '0;
    chk("midrst_ready", {31'b0, rdy[2]}, 32'd1);
    chk("midrst_rdata", rd[2], 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("midrst_no_rsp", {31'b0, rv[2]}, 32'd0);
      step();
    end
    txn(2, 1'b0, 32'h40, 32'h0, 4'h0);
    chk("midrst_commit", rd[2], 32'hCAFEF00D);

    // Misaligned accesses (error path when alignment checking is built in)
    txn(0, 1'b1, 32'h20, 32'h55667788, 4'hF);
    txn(0, 1'b1, 32'h22, 32'h99AABBCC, 4'hF);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0);
    txn(0, 1'b0, 32'h23, 32'h0, 4'h0);

    // Randomized traffic, including aliased upper address bits
    for (int n = 0; n < 150; n++) begin
      txn($urandom_range(0, NDUT - 1), 1'($urandom_range(0, 1)), $urandom,
          $urandom, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
